width_convert_gen_rdy_val: RTL and testbench
============================================

WIDTH_CONVERT_GEN_RDY_VAL -- requirements
Module: width_convert_gen_rdy_val

Interface
REQ-001 SHALL have parameter IN_DW, default 16, meaning input (tx) data width in bits.
REQ-002 SHALL have parameter OUT_DW, default 8, meaning output (bx) data width in bits.
REQ-003 SHALL define localparams RATIO = max(IN_DW,OUT_DW)/min(IN_DW,OUT_DW) and KEEP_W = (IN_DW<OUT_DW) ? RATIO : 1.
REQ-004 SHALL have port clk, input, 1, the single clock, rising edge.
REQ-005 SHALL have port rst_b, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port tx_valid, input, 1, upstream data valid.
REQ-007 SHALL have port tx_data, input, IN_DW, upstream data.
REQ-008 SHALL have port tx_last, input, 1, last beat of packet.
REQ-009 SHALL have port bx_rdy, output, 1, block can accept a tx beat.
REQ-010 SHALL have port rx_rdy, input, 1, downstream ready.
REQ-011 SHALL have port bx_valid, output, 1, output beat valid.
REQ-012 SHALL have port bx_data, output, OUT_DW, output data.
REQ-013 SHALL have port bx_last, output, 1, last beat of packet.
REQ-014 SHALL have port bx_keep, output, KEEP_W, per-IN_DW-slice valid mask (up mode); constant 1 otherwise.

Function
REQ-015 SHALL fail elaboration unless the larger width is an exact multiple of the smaller width.
REQ-016 SHALL select mode at elaboration: DOWN if IN_DW>OUT_DW, UP if IN_DW<OUT_DW, PASS if equal.
REQ-017 SHALL treat a transfer as occurring on a rising clk edge where valid and ready are both 1, on either side.
REQ-018 SHALL hold bx_data, bx_last and bx_keep stable while bx_valid=1 and rx_rdy=0.
REQ-019 DOWN: SHALL register the wide word and tx_last on tx transfer, then emit RATIO beats, slice 0 (LSBs) first, slice index from a counter of width max(1,$clog2(RATIO)).
REQ-020 DOWN: SHALL assert bx_last only on beat RATIO-1 and only if captured tx_last=1; bx_keep=1.
REQ-021 DOWN: bx_rdy = !bx_valid || (counter==RATIO-1 && rx_rdy), combinational, so a new wide word is accepted in the same cycle as the final narrow transfer.
REQ-022 DOWN: SHALL sustain one narrow beat per cycle with tx_valid and rx_rdy held high (no bubble between words).
REQ-023 UP: SHALL write tx_data into slice[counter] of a wide register, slice 0 first, setting keep[counter]=1.
REQ-024 UP: SHALL present the word (bx_valid=1) the cycle after slice RATIO-1 is written, or after any slice written with tx_last=1 (early flush); unfilled slices SHALL read 0 with keep bit 0.
REQ-025 UP: bx_last SHALL equal the tx_last of the final captured slice.
REQ-026 UP: bx_rdy = !bx_valid || rx_rdy, combinational; a tx beat arriving with the output transfer SHALL go into slice 0 of a cleared word.
REQ-027 UP/DOWN state machine: EMPTY (nothing held), FILL (UP only, partial word), FULL (bx_valid=1); EMPTY->FILL/FULL on tx transfer, FILL->FULL on final/last slice, FULL->EMPTY on output transfer without concurrent tx transfer, FULL->FILL/FULL with one.
REQ-028 PASS: SHALL act as a one-entry register slice, bx_rdy = !bx_valid || rx_rdy, latency 1 cycle.
REQ-029 Latency from tx transfer to first bx_valid SHALL be 1 cycle (DOWN/PASS) or 1 cycle after the completing slice (UP).
REQ-030 Counter SHALL wrap to 0 after RATIO-1 and after an early flush.

Reset
REQ-031 While rst_b=0: bx_valid=0, bx_data=0, bx_last=0, bx_keep=0 (UP) or 1 (DOWN/PASS), counter=0, state EMPTY, bx_rdy=1.
REQ-032 Reset asserted mid-packet SHALL discard all held data immediately; no partial beat SHALL be emitted after release.

Verification
REQ-033 DOWN 16->8: tx 0xA55A last=1, rx_rdy=1 -> bx 0x5A last=0, then 0xA5 last=1 on consecutive cycles.
REQ-034 DOWN 16->8 back-to-back: tx 0x1122,0x3344 held valid, rx_rdy=1 -> 22,11,44,33 on four consecutive cycles, bx_rdy high on cycles 2 and 4.
REQ-035 DOWN backpressure: rx_rdy=0 for 3 cycles during beat 0 -> bx_data stays 0x5A, bx_rdy=0, then completes.
REQ-036 UP 8->32: tx 11,22,33,44 last on 44 -> bx 0x44332211 keep=4'b1111 last=1.
REQ-037 UP early flush: tx 11,22 last on 22 -> bx 0x00002211 keep=4'b0011 last=1; next word starts at slice 0.
REQ-038 Reset mid-op: DOWN after beat 0 sent, pulse rst_b low -> bx_valid=0, bx_rdy=1; next tx 0xBEEF -> EF then BE.

Source files
------------

// File: rtl/width_convert_gen_rdy_val.sv
// Ready/valid width converter: splits wide words into narrow beats (DOWN), packs narrow
// beats into wide words with a keep mask (UP), or acts as a one-entry register slice (PASS).
module width_convert_gen_rdy_val #(
    parameter int unsigned IN_DW  = 16,
    parameter int unsigned OUT_DW = 8,
    localparam int unsigned MAX_DW = (IN_DW > OUT_DW) ? IN_DW : OUT_DW,
    localparam int unsigned MIN_DW = (IN_DW > OUT_DW) ? OUT_DW : IN_DW,
    localparam int unsigned RATIO  = MAX_DW / MIN_DW,
    localparam int unsigned KEEP_W = (IN_DW < OUT_DW) ? RATIO : 1
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              tx_valid,
    input  logic [IN_DW-1:0]  tx_data,
    input  logic              tx_last,
    output logic              bx_rdy,
    input  logic              rx_rdy,
    output logic              bx_valid,
    output logic [OUT_DW-1:0] bx_data,
    output logic              bx_last,
    output logic [KEEP_W-1:0] bx_keep
);

    localparam int unsigned CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATIO - 1);

    if ((MAX_DW % MIN_DW) != 0) begin : gen_bad_ratio
        $error("width_convert_gen_rdy_val: larger width must be a multiple of smaller width");
    end

    logic tx_xfer;
    logic bx_xfer;

    assign tx_xfer = tx_valid && bx_rdy;
    assign bx_xfer = bx_valid && rx_rdy;

    if (IN_DW > OUT_DW) begin : gen_down
        localparam logic [1:0] StEmpty = 2'd0;
        localparam logic [1:0] StFull  = 2'd2;

        logic [1:0]                   state_q, state_d;
        logic [CNT_W-1:0]             cnt_q, cnt_d;
        logic [RATIO-1:0][OUT_DW-1:0] word_q, word_d;
        logic                         last_q, last_d;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            word_d  = word_q;
            last_d  = last_q;
            // A new word may load in the same cycle the final narrow beat leaves.
            if (tx_xfer) begin
                word_d  = tx_data;
                last_d  = tx_last;
                cnt_d   = '0;
                state_d = StFull;
            end else if (bx_xfer) begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d   = '0;
                    state_d = StEmpty;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge rst_b) begin
            if (!rst_b) begin
                state_q <= StEmpty;
                cnt_q   <= '0;
                word_q  <= '0;
                last_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                word_q  <= word_d;
                last_q  <= last_d;
            end
        end

        assign bx_valid = (state_q == StFull);
        assign bx_rdy   = !bx_valid || ((cnt_q == CNT_MAX) && rx_rdy);
        assign bx_data  = word_q[cnt_q];
        assign bx_last  = bx_valid && last_q && (cnt_q == CNT_MAX);
        assign bx_keep  = 1'b1;
    end else if (IN_DW < OUT_DW) begin : gen_up
        localparam logic [1:0] StEmpty = 2'd0;
        localparam logic [1:0] StFill  = 2'd1;
        localparam logic [1:0] StFull  = 2'd2;

        logic [1:0]                  state_q, state_d;
        logic [CNT_W-1:0]            cnt_q, cnt_d;
        logic [RATIO-1:0][IN_DW-1:0] word_q, word_d;
        logic [RATIO-1:0]            keep_q, keep_d;
        logic                        last_q, last_d;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            word_d  = word_q;
            keep_d  = keep_q;
            last_d  = last_q;
            // Clear first so a concurrent tx beat lands in slice 0 of an empty word.
            if (bx_xfer) begin
                word_d  = '0;
                keep_d  = '0;
                last_d  = 1'b0;
                state_d = StEmpty;
            end
            if (tx_xfer) begin
                word_d[cnt_q] = tx_data;
                keep_d[cnt_q] = 1'b1;
                last_d        = tx_last;
                if ((cnt_q == CNT_MAX) || tx_last) begin
                    cnt_d   = '0;
                    state_d = StFull;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = StFill;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_b) begin
            if (!rst_b) begin
                state_q <= StEmpty;
                cnt_q   <= '0;
                word_q  <= '0;
                keep_q  <= '0;
                last_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                word_q  <= word_d;
                keep_q  <= keep_d;
                last_q  <= last_d;
            end
        end

        assign bx_valid = (state_q == StFull);
        assign bx_rdy   = !bx_valid || rx_rdy;
        assign bx_data  = word_q;
        assign bx_last  = last_q;
        assign bx_keep  = keep_q;
    end else begin : gen_pass
        logic              valid_q, valid_d;
        logic [IN_DW-1:0]  data_q, data_d;
        logic              last_q, last_d;

        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            last_d  = last_q;
            if (tx_xfer) begin
                valid_d = 1'b1;
                data_d  = tx_data;
                last_d  = tx_last;
            end else if (bx_xfer) begin
                valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst_b) begin
            if (!rst_b) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                last_q  <= 1'b0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
                last_q  <= last_d;
            end
        end

        assign bx_valid = valid_q;
        assign bx_rdy   = !valid_q || rx_rdy;
        assign bx_data  = data_q;
        assign bx_last  = last_q;
        assign bx_keep  = 1'b1;
    end

endmodule

// File: tb/tb_width_convert_gen_rdy_val.sv
// Directed bench for width_convert_gen_rdy_val in DOWN (16->8), UP (8->32) and PASS (8->8).
module tb_width_convert_gen_rdy_val;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DOWN 16->8
    logic        dn_tx_valid, dn_tx_last, dn_bx_rdy, dn_rx_rdy, dn_bx_valid, dn_bx_last;
    logic [15:0] dn_tx_data;
    logic [7:0]  dn_bx_data;
    logic [0:0]  dn_bx_keep;
    // UP 8->32
    logic        up_tx_valid, up_tx_last, up_bx_rdy, up_rx_rdy, up_bx_valid, up_bx_last;
    logic [7:0]  up_tx_data;
    logic [31:0] up_bx_data;
    logic [3:0]  up_bx_keep;
    // PASS 8->8
    logic        pa_tx_valid, pa_tx_last, pa_bx_rdy, pa_rx_rdy, pa_bx_valid, pa_bx_last;
    logic [7:0]  pa_tx_data;
    logic [7:0]  pa_bx_data;
    logic [0:0]  pa_bx_keep;

    width_convert_gen_rdy_val #(.IN_DW(16), .OUT_DW(8)) u_dn (
        .clk(clk), .rst_b(rst_b), .tx_valid(dn_tx_valid), .tx_data(dn_tx_data),
        .tx_last(dn_tx_last), .bx_rdy(dn_bx_rdy), .rx_rdy(dn_rx_rdy), .bx_valid(dn_bx_valid),
        .bx_data(dn_bx_data), .bx_last(dn_bx_last), .bx_keep(dn_bx_keep)
    );

    width_convert_gen_rdy_val #(.IN_DW(8), .OUT_DW(32)) u_up (
        .clk(clk), .rst_b(rst_b), .tx_valid(up_tx_valid), .tx_data(up_tx_data),
        .tx_last(up_tx_last), .bx_rdy(up_bx_rdy), .rx_rdy(up_rx_rdy), .bx_valid(up_bx_valid),
        .bx_data(up_bx_data), .bx_last(up_bx_last), .bx_keep(up_bx_keep)
    );

    width_convert_gen_rdy_val #(.IN_DW(8), .OUT_DW(8)) u_pa (
        .clk(clk), .rst_b(rst_b), .tx_valid(pa_tx_valid), .tx_data(pa_tx_data),
        .tx_last(pa_tx_last), .bx_rdy(pa_bx_rdy), .rx_rdy(pa_rx_rdy), .bx_valid(pa_bx_valid),
        .bx_data(pa_bx_data), .bx_last(pa_bx_last), .bx_keep(pa_bx_keep)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic dn_drive(input logic v, input logic [15:0] d, input logic l, input logic r);
        dn_tx_valid = v;
        dn_tx_data  = d;
        dn_tx_last  = l;
        dn_rx_rdy   = r;
        #1;
    endtask

    task automatic dn_expect(input string tag, input logic v, input logic [7:0] d,
                             input logic l, input logic rdy);
        check({tag, ".valid"}, 64'(dn_bx_valid), 64'(v));
        if (v) begin
            check({tag, ".data"}, 64'(dn_bx_data), 64'(d));
            check({tag, ".last"}, 64'(dn_bx_last), 64'(l));
        end
        check({tag, ".rdy"}, 64'(dn_bx_rdy), 64'(rdy));
    endtask

    task automatic up_drive(input logic v, input logic [7:0] d, input logic l, input logic r);
        up_tx_valid = v;
        up_tx_data  = d;
        up_tx_last  = l;
        up_rx_rdy   = r;
        #1;
    endtask

    task automatic up_expect(input string tag, input logic [31:0] d, input logic [3:0] k,
                             input logic l, input logic rdy);
        check({tag, ".valid"}, 64'(up_bx_valid), 64'(1));
        check({tag, ".data"}, 64'(up_bx_data), 64'(d));
        check({tag, ".keep"}, 64'(up_bx_keep), 64'(k));
        check({tag, ".last"}, 64'(up_bx_last), 64'(l));
        check({tag, ".rdy"}, 64'(up_bx_rdy), 64'(rdy));
    endtask

    initial begin
        dn_tx_valid = 0; dn_tx_data = '0; dn_tx_last = 0; dn_rx_rdy = 1;
        up_tx_valid = 0; up_tx_data = '0; up_tx_last = 0; up_rx_rdy = 1;
        pa_tx_valid = 0; pa_tx_data = '0; pa_tx_last = 0; pa_rx_rdy = 1;
        rst_b = 1'b0;
        @(negedge clk);
        #1;
        check("rst.dn_valid", 64'(dn_bx_valid), 64'(0));
        check("rst.dn_data", 64'(dn_bx_data), 64'(0));
        check("rst.dn_last", 64'(dn_bx_last), 64'(0));
        check("rst.dn_keep", 64'(dn_bx_keep), 64'(1));
        check("rst.dn_rdy", 64'(dn_bx_rdy), 64'(1));
        check("rst.up_valid", 64'(up_bx_valid), 64'(0));
        check("rst.up_data", 64'(up_bx_data), 64'(0));
        check("rst.up_keep", 64'(up_bx_keep), 64'(0));
        check("rst.up_rdy", 64'(up_bx_rdy), 64'(1));
        check("rst.pa_valid", 64'(pa_bx_valid), 64'(0));
        check("rst.pa_keep", 64'(pa_bx_keep), 64'(1));
        tick();
        rst_b = 1'b1;

        // DOWN single word, last=1
        dn_drive(1, 16'hA55A, 1, 1);
        check("dn1.accept_rdy", 64'(dn_bx_rdy), 64'(1));
        tick();
        dn_drive(0, 16'h0000, 0, 1);
        dn_expect("dn1.b0", 1, 8'h5A, 0, 0);
        tick();
        dn_expect("dn1.b1", 1, 8'hA5, 1, 1);
        tick();
        dn_expect("dn1.idle", 0, 8'h00, 0, 1);

        // DOWN back-to-back words with tx_valid held
        dn_drive(1, 16'h1122, 0, 1);
        tick();
        dn_drive(1, 16'h3344, 0, 1);
        dn_expect("dn2.b0", 1, 8'h22, 0, 0);
        tick();
        dn_expect("dn2.b1", 1, 8'h11, 0, 1);
        tick();
        dn_drive(0, 16'h0000, 0, 1);
        dn_expect("dn2.b2", 1, 8'h44, 0, 0);
        tick();
        dn_expect("dn2.b3", 1, 8'h33, 0, 1);
        tick();
        dn_expect("dn2.idle", 0, 8'h00, 0, 1);

        // DOWN backpressure on beat 0
        dn_drive(1, 16'hA55A, 1, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            dn_drive(0, 16'h0000, 0, 0);
            dn_expect($sformatf("dn3.hold%0d", i), 1, 8'h5A, 0, 0);
            tick();
        end
        dn_drive(0, 16'h0000, 0, 1);
        dn_expect("dn3.b0", 1, 8'h5A, 0, 0);
        tick();
        dn_expect("dn3.b1", 1, 8'hA5, 1, 1);
        tick();
        dn_expect("dn3.idle", 0, 8'h00, 0, 1);

        // UP full word 11,22,33,44 with last on 44
        up_drive(1, 8'h11, 0, 1);
        tick();
        up_drive(1, 8'h22, 0, 1);
        check("up1.filling_valid", 64'(up_bx_valid), 64'(0));
        tick();
        up_drive(1, 8'h33, 0, 1);
        tick();
        up_drive(1, 8'h44, 1, 1);
        tick();
        up_drive(0, 8'h00, 0, 1);
        up_expect("up1.word", 32'h44332211, 4'b1111, 1, 1);
        tick();
        check("up1.idle_valid", 64'(up_bx_valid), 64'(0));
        check("up1.idle_keep", 64'(up_bx_keep), 64'(0));

        // UP early flush, backpressure, then concurrent beat into slice 0
        up_drive(1, 8'h11, 0, 1);
        tick();
        up_drive(1, 8'h22, 1, 1);
        tick();
        up_drive(0, 8'h00, 0, 0);
        up_expect("up2.flush_hold", 32'h00002211, 4'b0011, 1, 0);
        tick();
        up_drive(1, 8'h55, 1, 1);
        up_expect("up2.flush", 32'h00002211, 4'b0011, 1, 1);
        tick();
        up_drive(0, 8'h00, 0, 1);
        up_expect("up2.next", 32'h00000055, 4'b0001, 1, 1);
        tick();
        check("up2.idle_valid", 64'(up_bx_valid), 64'(0));

        // PASS register slice
        pa_tx_valid = 1; pa_tx_data = 8'h5C; pa_tx_last = 1; pa_rx_rdy = 1;
        #1;
        tick();
        pa_tx_valid = 0;
        #1;
        check("pa.valid", 64'(pa_bx_valid), 64'(1));
        check("pa.data", 64'(pa_bx_data), 64'(8'h5C));
        check("pa.last", 64'(pa_bx_last), 64'(1));
        tick();
        check("pa.idle", 64'(pa_bx_valid), 64'(0));

        // DOWN reset after beat 0 has been sent
        dn_drive(1, 16'hA55A, 1, 1);
        tick();
        dn_drive(0, 16'h0000, 0, 1);
        dn_expect("dn4.b0", 1, 8'h5A, 0, 0);
        tick();
        rst_b = 1'b0;
        #1;
        check("dn4.rst_valid", 64'(dn_bx_valid), 64'(0));
        check("dn4.rst_rdy", 64'(dn_bx_rdy), 64'(1));
        check("dn4.rst_data", 64'(dn_bx_data), 64'(0));
        tick();
        rst_b = 1'b1;
        dn_drive(0, 16'h0000, 0, 1);
        dn_expect("dn4.after_rst", 0, 8'h00, 0, 1);
        tick();
        dn_drive(1, 16'hBEEF, 0, 1);
        tick();
        dn_drive(0, 16'h0000, 0, 1);
        dn_expect("dn4.b0new", 1, 8'hEF, 0, 0);
        tick();
        dn_expect("dn4.b1new", 1, 8'hBE, 0, 1);
        tick();
        dn_expect("dn4.idle", 0, 8'h00, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
